// File: rtl/zorro_autoconfig.sv
//==============================================================================
// Module   : zorro_autoconfig
// Purpose  : Zorro II AutoConfig responder and 128K I/O window decoder for the
//            IDE controller card.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module zorro_autoconfig #(
    parameter logic [15:0] MANUF_ID = 16'h07DB,
    parameter logic [7:0]  PROD_ID  = 8'h05,
    parameter logic [31:0] SERIAL   = 32'h00000001,
    parameter logic [15:0] DIAG_VEC = 16'h4000
) (
    input  logic        CLK,
    input  logic        RESET_n,
    input  logic [23:1] ADDR,
    input  logic        AS_n,
    input  logic        UDS_n,
    input  logic        RW,
    input  logic [3:0]  DIN,
    input  logic        CFGIN_n,
    output logic [3:0]  DOUT,
    output logic        DOE,
    output logic        CFGOUT_n,
    output logic        ac_access,
    output logic        ide_access,
    output logic        configured
);

    typedef enum logic [1:0] {
        ST_UNCONF = 2'd0,
        ST_CONF   = 2'd1,
        ST_SHUTUP = 2'd2
    } state_t;

    localparam logic [6:0] c_REG_BASE_HI = 7'h24;   // byte offset $48
    localparam logic [6:0] c_REG_BASE_LO = 7'h25;   // byte offset $4A
    localparam logic [6:0] c_REG_SHUTUP  = 7'h26;   // byte offset $4C

    state_t      r_state;
    logic [23:17] r_base;
    logic [3:1]  r_hi_nib;
    logic        r_wr_done;
    logic        r_configured;
    logic        r_cfgout_n;

    logic        w_cfg_space;
    logic        w_wstb;
    logic [6:0]  w_reg;
    logic [3:0]  w_rom_nib;
    logic        w_unused_addr;

    assign w_reg         = ADDR[7:1];
    assign w_cfg_space   = (ADDR[23:16] == 8'hE8);
    assign w_unused_addr = ^ADDR[15:8];

    // Gating with RESET_n keeps the bus quiet while reset is held.
    assign ac_access  = RESET_n && !AS_n && (r_state == ST_UNCONF) && !CFGIN_n && w_cfg_space;
    assign ide_access = RESET_n && !AS_n && (r_state == ST_CONF) && (ADDR[23:17] == r_base)
                        && !r_wr_done;
    assign w_wstb     = ac_access && !RW && !UDS_n && !r_wr_done;

    assign DOE        = ac_access && RW;
    assign DOUT       = DOE ? w_rom_nib : 4'hF;
    assign configured = r_configured;
    assign CFGOUT_n   = r_cfgout_n;

    // Everything past the first two nibbles is stored inverted on the bus.
    always_comb begin
        w_rom_nib = 4'hF;
        case (w_reg)
            7'h00: w_rom_nib = 4'hD;
            7'h01: w_rom_nib = 4'h2;
            7'h02: w_rom_nib = ~PROD_ID[7:4];
            7'h03: w_rom_nib = ~PROD_ID[3:0];
            7'h04: w_rom_nib = ~4'hC;
            7'h08: w_rom_nib = ~MANUF_ID[15:12];
            7'h09: w_rom_nib = ~MANUF_ID[11:8];
            7'h0A: w_rom_nib = ~MANUF_ID[7:4];
            7'h0B: w_rom_nib = ~MANUF_ID[3:0];
            7'h0C: w_rom_nib = ~SERIAL[31:28];
            7'h0D: w_rom_nib = ~SERIAL[27:24];
            7'h0E: w_rom_nib = ~SERIAL[23:20];
            7'h0F: w_rom_nib = ~SERIAL[19:16];
            7'h10: w_rom_nib = ~SERIAL[15:12];
            7'h11: w_rom_nib = ~SERIAL[11:8];
            7'h12: w_rom_nib = ~SERIAL[7:4];
            7'h13: w_rom_nib = ~SERIAL[3:0];
            7'h14: w_rom_nib = ~DIAG_VEC[15:12];
            7'h15: w_rom_nib = ~DIAG_VEC[11:8];
            7'h16: w_rom_nib = ~DIAG_VEC[7:4];
            7'h17: w_rom_nib = ~DIAG_VEC[3:0];
            7'h20: w_rom_nib = 4'h0;
            7'h21: w_rom_nib = 4'h0;
            default: w_rom_nib = 4'hF;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state      <= ST_UNCONF;
            r_base       <= 7'd0;
            r_hi_nib     <= 3'd0;
            r_wr_done    <= 1'b0;
            r_configured <= 1'b0;
            r_cfgout_n   <= 1'b1;
        end else begin
            // One register action per AS_n low period, however long it lasts.
            if (w_wstb) begin
                r_wr_done <= 1'b1;
            end else if (AS_n) begin
                r_wr_done <= 1'b0;
            end

            if (w_wstb) begin
                case (w_reg)
                    c_REG_BASE_LO: begin
                        r_hi_nib <= DIN[3:1];
                    end
                    c_REG_BASE_HI: begin
                        r_base       <= {DIN, r_hi_nib};
                        r_state      <= ST_CONF;
                        r_configured <= 1'b1;
                        r_cfgout_n   <= 1'b0;
                    end
                    c_REG_SHUTUP: begin
                        r_state      <= ST_SHUTUP;
                        r_configured <= 1'b0;
                        r_cfgout_n   <= 1'b0;
                    end
                    default: begin
                        r_state <= r_state;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_zorro_autoconfig.sv
//==============================================================================
// Module   : tb_zorro_autoconfig
// Purpose  : Randomized bus-cycle bench for zorro_autoconfig against a
//            behavioural AutoConfig model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_zorro_autoconfig;

    localparam logic [15:0] c_MANUF  = 16'h07DB;
    localparam logic [7:0]  c_PROD   = 8'h05;
    localparam logic [31:0] c_SERIAL = 32'h00000001;
    localparam logic [15:0] c_DIAG   = 16'h4000;

    logic        CLK;
    logic        RESET_n;
    logic [23:1] ADDR;
    logic        AS_n;
    logic        UDS_n;
    logic        RW;
    logic [3:0]  DIN;
    logic        CFGIN_n;
    logic [3:0]  DOUT;
    logic        DOE;
    logic        CFGOUT_n;
    logic        ac_access;
    logic        ide_access;
    logic        configured;

    int n_checks;
    int n_fail;

    // Behavioural model: board condition plus the expected config ROM by byte offset.
    logic        m_unconf;
    logic        m_conf;
    logic [6:0]  m_base;
    logic [3:0]  m_hi;
    logic [3:0]  rom [256];

    zorro_autoconfig #(
        .MANUF_ID (c_MANUF),
        .PROD_ID  (c_PROD),
        .SERIAL   (c_SERIAL),
        .DIAG_VEC (c_DIAG)
    ) u_dut (
        .CLK        (CLK),
        .RESET_n    (RESET_n),
        .ADDR       (ADDR),
        .AS_n       (AS_n),
        .UDS_n      (UDS_n),
        .RW         (RW),
        .DIN        (DIN),
        .CFGIN_n    (CFGIN_n),
        .DOUT       (DOUT),
        .DOE        (DOE),
        .CFGOUT_n   (CFGOUT_n),
        .ac_access  (ac_access),
        .ide_access (ide_access),
        .configured (configured)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic build_rom();
        for (int b = 0; b < 256; b++) rom[b] = 4'hF;
        rom[8'h00] = 4'hD;
        rom[8'h02] = 4'h2;
        rom[8'h04] = ~c_PROD[7:4];
        rom[8'h06] = ~c_PROD[3:0];
        rom[8'h08] = 4'h3;
        for (int i = 0; i < 4; i++) rom[8'h10 + 2*i] = ~c_MANUF[15-4*i -: 4];
        for (int i = 0; i < 8; i++) rom[8'h18 + 2*i] = ~c_SERIAL[31-4*i -: 4];
        for (int i = 0; i < 4; i++) rom[8'h28 + 2*i] = ~c_DIAG[15-4*i -: 4];
        rom[8'h40] = 4'h0;
        rom[8'h42] = 4'h0;
    endtask

    task automatic model_reset();
        m_unconf = 1'b1;
        m_conf   = 1'b0;
        m_base   = 7'd0;
        m_hi     = 4'd0;
    endtask

    task automatic reset_dut();
        RESET_n = 1'b0;
        AS_n    = 1'b1;
        UDS_n   = 1'b1;
        RW      = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RESET_n = 1'b1;
        model_reset();
        @(negedge CLK);
        check_eq("rst_configured", 32'(configured), 32'(0));
        check_eq("rst_cfgout_n", 32'(CFGOUT_n), 32'(1));
        check_eq("rst_doe", 32'(DOE), 32'(0));
        check_eq("rst_dout", 32'(DOUT), 32'(4'hF));
    endtask

    // One 68000 bus cycle; waits = extra clock edges with AS_n held low.
    task automatic bus_cycle(input logic [23:0] a, input logic rw, input logic uds_n,
                             input logic [3:0] din, input int waits);
        logic hit;
        logic stb;
        logic in_win;
        @(posedge CLK);
        #1;
        ADDR  = a[23:1];
        RW    = rw;
        UDS_n = uds_n;
        DIN   = din;
        AS_n  = 1'b0;
        hit    = m_unconf && !CFGIN_n && (a[23:16] == 8'hE8);
        stb    = hit && !rw && !uds_n;
        in_win = (a[23:17] == m_base);
        @(negedge CLK);
        check_eq("ac_access", 32'(ac_access), 32'(hit));
        check_eq("doe", 32'(DOE), 32'(hit && rw));
        if (hit && rw) check_eq("dout", 32'(DOUT), 32'(rom[{a[7:1], 1'b0}]));
        check_eq("ide_access", 32'(ide_access), 32'(m_conf && in_win));
        @(posedge CLK);
        #1;
        if (stb) begin
            case ({a[7:1], 1'b0})
                8'h4A: m_hi = din;
                8'h48: begin
                    m_base   = {din, m_hi[3:1]};
                    m_unconf = 1'b0;
                    m_conf   = 1'b1;
                end
                8'h4C: m_unconf = 1'b0;
                default: ;
            endcase
        end
        DIN = ~din;
        @(negedge CLK);
        check_eq("configured", 32'(configured), 32'(m_conf));
        check_eq("cfgout_n", 32'(CFGOUT_n), 32'(m_unconf));
        check_eq("ide_in_cycle", 32'(ide_access),
                 32'(m_conf && (a[23:17] == m_base) && !stb));
        repeat (waits) @(posedge CLK);
        #1;
        AS_n  = 1'b1;
        UDS_n = 1'b1;
        RW    = 1'b1;
    endtask

    function automatic logic [23:0] cfg_addr(input logic [7:0] off);
        return {8'hE8, 8'($urandom), off[7:1], 1'b0};
    endfunction

    function automatic logic [23:0] rand_addr();
        logic [23:0] a;
        case ($urandom_range(0, 3))
            0:       a = cfg_addr(8'($urandom));
            1, 2:    a = {m_base, 17'($urandom)};
            default: a = 24'($urandom);
        endcase
        a[0] = 1'b0;
        return a;
    endfunction

    initial begin
        logic [7:0] off;
        n_checks = 0;
        n_fail   = 0;
        ADDR     = '0;
        DIN      = '0;
        CFGIN_n  = 1'b0;
        build_rom();
        reset_dut();

        // Directed ROM reads, then random reads in the unconfigured state.
        bus_cycle(24'hE80000, 1'b1, 1'b0, 4'h0, 0);
        bus_cycle(24'hE80002, 1'b1, 1'b0, 4'h0, 1);
        for (int i = 0; i < 4; i++) bus_cycle(24'hE80010 + 24'(2*i), 1'b1, 1'b0, 4'h0, 0);
        repeat (150) begin
            CFGIN_n = ($urandom_range(0, 3) == 0);
            bus_cycle(cfg_addr(8'($urandom)), 1'b1, 1'($urandom), 4'($urandom),
                      $urandom_range(0, 2));
        end

        // Random non-committing writes: hi_nib loads, LDS-only, CFGIN_n high, ignored offsets.
        repeat (60) begin
            off = 8'($urandom_range(0, 127) * 2);
            if (off == 8'h48 || off == 8'h4C || $urandom_range(0, 1) == 1) off = 8'h4A;
            CFGIN_n = ($urandom_range(0, 3) == 0);
            bus_cycle(cfg_addr(off), 1'b0, ($urandom_range(0, 3) == 0), 4'($urandom),
                      $urandom_range(0, 4));
        end
        CFGIN_n = 1'b0;
        bus_cycle(24'hE80048, 1'b0, 1'b0, 4'($urandom), 3);
        repeat (100) bus_cycle(rand_addr(), 1'($urandom), 1'($urandom), 4'($urandom),
                               $urandom_range(0, 2));

        // Known assignment $E4, wait-stated commit, then a second $48 cycle.
        reset_dut();
        bus_cycle(24'hE8004A, 1'b0, 1'b0, 4'h4, 0);
        bus_cycle(24'hE80048, 1'b0, 1'b0, 4'hE, 4);
        bus_cycle(24'hE80048, 1'b0, 1'b0, 4'h2, 0);
        bus_cycle(24'hE40000, 1'b1, 1'b0, 4'h0, 0);
        check_eq("ide_E40000", 32'(ide_access), 32'(1));
        bus_cycle(24'hE5FFFE, 1'b1, 1'b0, 4'h0, 0);
        check_eq("ide_E5FFFE", 32'(ide_access), 32'(1));
        bus_cycle(24'hE60000, 1'b1, 1'b0, 4'h0, 0);
        check_eq("ide_E60000", 32'(ide_access), 32'(0));
        bus_cycle(24'hE80000, 1'b1, 1'b0, 4'h0, 0);

        // Shut-up: never configures, never decodes.
        reset_dut();
        bus_cycle(24'hE8004C, 1'b0, 1'b0, 4'h0, 2);
        bus_cycle(24'hE80048, 1'b0, 1'b0, 4'h0, 0);
        repeat (30) bus_cycle(rand_addr(), 1'($urandom), 1'($urandom), 4'($urandom), 0);

        // CFGIN_n high ignores everything; then $48 without a prior $4A.
        reset_dut();
        CFGIN_n = 1'b1;
        bus_cycle(24'hE80048, 1'b1, 1'b0, 4'h0, 0);
        bus_cycle(24'hE80048, 1'b0, 1'b0, 4'h6, 1);
        CFGIN_n = 1'b0;
        bus_cycle(24'hE80048, 1'b0, 1'b0, 4'($urandom), 0);
        repeat (30) bus_cycle(rand_addr(), 1'b1, 1'b0, 4'h0, 0);

        // Reset in the middle of a window access while configured.
        @(posedge CLK);
        #1;
        ADDR = {m_base, 16'h0};
        RW   = 1'b1;
        AS_n = 1'b0;
        @(negedge CLK);
        check_eq("pre_rst_ide", 32'(ide_access), 32'(1));
        check_eq("pre_rst_cfg", 32'(configured), 32'(1));
        #2;
        RESET_n = 1'b0;
        #1;
        check_eq("async_rst_cfg", 32'(configured), 32'(0));
        check_eq("async_rst_cfgout", 32'(CFGOUT_n), 32'(1));
        check_eq("async_rst_ide", 32'(ide_access), 32'(0));
        AS_n = 1'b1;
        reset_dut();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
